// File: rtl/rp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rp_pkg
//  Description : Shared types for the resource pool manager: request opcode,
//                control FSM state and the counter full-scale helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package rp_pkg;

    typedef enum logic {
        OP_CONSUME = 1'b0,
        OP_REFILL  = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Full-scale value of a w-bit saturating counter.
    function automatic int unsigned rp_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rp_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : rp_addsub
//  Description : CNT_W-bit adder/subtractor with one extra result bit.
//                For an add the extra bit is the carry-out, for a subtract it
//                is the borrow (a < b).
//  Ports       : i_a, i_b  operands
//                i_sub     1 = a - b, 0 = a + b
//                o_res     low CNT_W bits of the result
//                o_cout    carry (add) / borrow (sub)
//  Revision    : 1.0 - initial release
// ============================================================================
module rp_addsub #(
    parameter int CNT_W = 8
) (
    input  logic [CNT_W-1:0] i_a,
    input  logic [CNT_W-1:0] i_b,
    input  logic             i_sub,
    output logic [CNT_W-1:0] o_res,
    output logic             o_cout
);

    logic [CNT_W:0] w_full;

    assign w_full = i_sub ? ({1'b0, i_a} - {1'b0, i_b})
                          : ({1'b0, i_a} + {1'b0, i_b});
    assign o_res  = w_full[CNT_W-1:0];
    assign o_cout = w_full[CNT_W];

endmodule
`default_nettype wire

// File: rtl/resource_pool_manager.sv
`default_nettype none
// ============================================================================
//  Module      : resource_pool_manager
//  Description : NUM_CH saturating resource counters (CNT_W bits each) served
//                by a consume/refill request channel with a valid/ready
//                request and response handshake. Each request takes
//                IDLE -> EXEC -> RESP; registered low-water flags per channel.
//  Build macro : AUTO_RECHARGE_EN - adds a free-running recharge period that
//                bumps every non-full channel by one each RECHG_PER cycles.
//  Ports       : clk, reset (async, active-high), reload (refill all, IDLE)
//                req_valid/req_ready/req_ch/req_op/req_amt  request channel
//                rsp_valid/rsp_ready/rsp_ok/rsp_sat/rsp_level  response
//                level (ch0 in LSBs), low_flag (level < LOW_THRESH)
//  Revision    : 1.0 - initial release
// ============================================================================
module resource_pool_manager
    import rp_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int CNT_W      = 8,
    parameter int LOW_THRESH = 16,
    parameter int RECHG_PER  = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    reload,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [2:0]              req_ch,
    input  logic                    req_op,
    input  logic [CNT_W-1:0]        req_amt,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_ok,
    output logic                    rsp_sat,
    output logic [CNT_W-1:0]        rsp_level,
    output logic [NUM_CH*CNT_W-1:0] level,
    output logic [NUM_CH-1:0]       low_flag
);

    localparam logic [CNT_W-1:0] c_MAX = CNT_W'(rp_max(CNT_W));

    state_e             r_state;
    state_e             w_state_nxt;
    logic [2:0]         r_ch;
    op_e                r_op;
    logic [CNT_W-1:0]   r_amt;
    logic [CNT_W-1:0]   r_level [NUM_CH];
    logic [NUM_CH-1:0]  r_low_flag;
    logic               r_rsp_ok;
    logic               r_rsp_sat;
    logic [CNT_W-1:0]   r_rsp_level;

    logic               w_accept;
    logic               w_reload_now;
    logic               w_exec;
    logic               w_ch_ok;
    logic [CNT_W-1:0]   w_cur;
    logic [CNT_W-1:0]   w_res;
    logic               w_cout;
    logic               w_ok;
    logic               w_sat;
    logic [CNT_W-1:0]   w_new;
    logic               w_tick;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        w_accept     = 1'b0;
        w_reload_now = 1'b0;
        w_exec       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready    = !reload;
                w_reload_now = reload;
                if (req_valid && !reload) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_exec      = 1'b1;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Execute datapath
    // ------------------------------------------------------------------
    assign w_ch_ok = (32'(r_ch) < NUM_CH);

    always_comb begin
        w_cur = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (32'(r_ch) == i) begin
                w_cur = r_level[i];
            end
        end
    end

    rp_addsub #(
        .CNT_W (CNT_W)
    ) u_addsub (
        .i_a    (w_cur),
        .i_b    (r_amt),
        .i_sub  (r_op == OP_CONSUME),
        .o_res  (w_res),
        .o_cout (w_cout)
    );

    // For a consume w_cout is the borrow (reject); for a refill it is the
    // carry (clip to full scale).
    always_comb begin
        w_ok  = 1'b0;
        w_sat = 1'b0;
        w_new = '0;
        if (w_ch_ok) begin
            if (r_op == OP_CONSUME) begin
                w_ok  = !w_cout;
                w_new = w_cout ? w_cur : w_res;
            end else begin
                w_ok  = 1'b1;
                w_sat = w_cout;
                w_new = w_cout ? c_MAX : w_res;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional recharge period
    // ------------------------------------------------------------------
`ifdef AUTO_RECHARGE_EN
    localparam int c_RC_W = (RECHG_PER > 1) ? $clog2(RECHG_PER) : 1;
    logic [c_RC_W-1:0] r_rc_cnt;

    assign w_tick = (32'(r_rc_cnt) == RECHG_PER - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rc_cnt <= '0;
        end else if (w_reload_now || w_tick) begin
            r_rc_cnt <= '0;
        end else begin
            r_rc_cnt <= r_rc_cnt + c_RC_W'(1);
        end
    end
`else
    assign w_tick = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Levels, flags and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ch        <= '0;
            r_op        <= OP_CONSUME;
            r_amt       <= '0;
            r_rsp_ok    <= 1'b0;
            r_rsp_sat   <= 1'b0;
            r_rsp_level <= '0;
            r_low_flag  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_level[i] <= c_MAX;
            end
        end else begin
            if (w_accept) begin
                r_ch  <= req_ch;
                r_op  <= op_e'(req_op);
                r_amt <= req_amt;
            end
            if (w_exec) begin
                r_rsp_ok    <= w_ok;
                r_rsp_sat   <= w_sat;
                r_rsp_level <= w_new;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                // The channel targeted in EXEC owns its update that cycle, so
                // a coinciding recharge tick is dropped for it.
                if (w_reload_now) begin
                    r_level[i] <= c_MAX;
                end else if (w_exec && w_ch_ok && (32'(r_ch) == i)) begin
                    if (w_ok) begin
                        r_level[i] <= w_new;
                    end
                end else if (w_tick && (r_level[i] != c_MAX)) begin
                    r_level[i] <= r_level[i] + CNT_W'(1);
                end
                r_low_flag[i] <= (32'(r_level[i]) < LOW_THRESH);
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign level[g*CNT_W +: CNT_W] = r_level[g];
    end

    assign rsp_ok    = r_rsp_ok;
    assign rsp_sat   = r_rsp_sat;
    assign rsp_level = r_rsp_level;
    assign low_flag  = r_low_flag;

endmodule
`default_nettype wire
